// File: rtl/reg_write_demux.sv
// reg_write_demux
// Write-side router for the 8-bit bus. Byte writes are steered to the counter
// or to register_2 using the same select codes as the readback mux. The
// register_2 MSB is staged, and the full 16-bit value is committed in one edge
// when the matching LSB arrives.
//
// Ports
//   clk                 in   system clock, rising edge
//   reset               in   synchronous, active-high reset
//   wr_en               in   write request, accepted when wr_en && ready
//   sel                 in   target select code
//   data_in             in   write data byte
//   ready               out  a write can be accepted this cycle
//   ack                 out  1-cycle pulse in the cycle after an accepted write
//   error               out  1-cycle pulse alongside ack when the write was rejected
//   counter_load        out  1-cycle pulse: load the counter from counter_load_value
//   counter_load_value  out  counter load data, held until the next counter write
//   counter_carry_clr   out  1-cycle pulse: clear the counter carry flag
//   register_2_we       out  1-cycle pulse: register_2_value is ready to commit
//   register_2_value    out  {msb, lsb}, held until the next commit
//   reg2_pending        out  an MSB is staged and waiting for its LSB
//
// state    | meaning
// ---------+------------------------------------------
// IDLE     | no MSB staged
// MSB_HELD | msb_hold is valid, waiting for the LSB

module reg_write_demux #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [2:0]              sel,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    ready,
    output logic                    ack,
    output logic                    error,
    output logic                    counter_load,
    output logic [DATA_WIDTH-1:0]   counter_load_value,
    output logic                    counter_carry_clr,
    output logic                    register_2_we,
    output logic [2*DATA_WIDTH-1:0] register_2_value,
    output logic                    reg2_pending
);

    // These select codes must match the codes used by the readback mux.
    localparam logic [2:0] MUX_SEL_COUNTER_VALUE  = 3'd0;
    localparam logic [2:0] MUX_SEL_COUNTER_CARRY  = 3'd1;
    localparam logic [2:0] MUX_SEL_REGISTER_2_MSB = 3'd2;
    localparam logic [2:0] MUX_SEL_REGISTER_2_LSB = 3'd3;

    typedef enum logic {
        IDLE     = 1'b0,
        MSB_HELD = 1'b1
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] msb_hold;
    logic                  accept;

    // Deriving ready from ack forces one idle cycle after every accepted write.
    assign ready  = ~ack;
    assign accept = wr_en & ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            msb_hold           <= '0;
            ack                <= 1'b0;
            error              <= 1'b0;
            counter_load       <= 1'b0;
            counter_load_value <= '0;
            counter_carry_clr  <= 1'b0;
            register_2_we      <= 1'b0;
            register_2_value   <= '0;
            reg2_pending       <= 1'b0;
        end else begin
            // Pulse outputs are cleared by default, so each one lasts a single cycle.
            ack               <= 1'b0;
            error             <= 1'b0;
            counter_load      <= 1'b0;
            counter_carry_clr <= 1'b0;
            register_2_we     <= 1'b0;

            if (accept) begin
                ack <= 1'b1;
                case (sel)
                    MUX_SEL_COUNTER_VALUE: begin
                        counter_load_value <= data_in;
                        counter_load       <= 1'b1;
                    end
                    MUX_SEL_COUNTER_CARRY: begin
                        counter_carry_clr <= data_in[0];
                    end
                    MUX_SEL_REGISTER_2_MSB: begin
                        // A repeated MSB simply replaces the staged byte.
                        msb_hold     <= data_in;
                        state        <= MSB_HELD;
                        reg2_pending <= 1'b1;
                    end
                    MUX_SEL_REGISTER_2_LSB: begin
                        if (state == MSB_HELD) begin
                            // Both bytes land on this single edge.
                            register_2_value <= {msb_hold, data_in};
                            register_2_we    <= 1'b1;
                            state            <= IDLE;
                            reg2_pending     <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    default: begin
                        error <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reg_write_demux.sv
module tb_reg_write_demux;

    localparam logic [2:0] SEL_CV  = 3'd0;
    localparam logic [2:0] SEL_CC  = 3'd1;
    localparam logic [2:0] SEL_MSB = 3'd2;
    localparam logic [2:0] SEL_LSB = 3'd3;
    localparam logic [2:0] SEL_BAD = 3'd7;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  sel;
    logic [7:0]  data_in;
    logic        ready;
    logic        ack;
    logic        error;
    logic        counter_load;
    logic [7:0]  counter_load_value;
    logic        counter_carry_clr;
    logic        register_2_we;
    logic [15:0] register_2_value;
    logic        reg2_pending;

    int n_cmp;
    int n_bad;
    int we_count;

    reg_write_demux #(.DATA_WIDTH(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .wr_en              (wr_en),
        .sel                (sel),
        .data_in            (data_in),
        .ready              (ready),
        .ack                (ack),
        .error              (error),
        .counter_load       (counter_load),
        .counter_load_value (counter_load_value),
        .counter_carry_clr  (counter_carry_clr),
        .register_2_we      (register_2_we),
        .register_2_value   (register_2_value),
        .reg2_pending       (reg2_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count commit pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (register_2_we) we_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_cmp++;
        if (obs !== exp_val) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_val);
        end
    endtask

    // Drive one write. The task returns 1 time unit after the accept edge,
    // which is the cycle in which ack and the write's effects are visible.
    task automatic wr(input logic [2:0] s, input logic [7:0] d);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (ready) break;
            @(negedge clk);
        end
        check("ready_before_wr", 32'(ready), 32'd1);
        wr_en   = 1'b1;
        sel     = s;
        data_in = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        we_count = 0;
        reset    = 1'b1;
        wr_en    = 1'b0;
        sel      = 3'd0;
        data_in  = 8'h00;

        // 1 reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cload", 32'(counter_load), 32'd0);
        check("rst_clv", 32'(counter_load_value), 32'h00);
        check("rst_cclr", 32'(counter_carry_clr), 32'd0);
        check("rst_we", 32'(register_2_we), 32'd0);
        check("rst_r2v", 32'(register_2_value), 32'h0000);
        check("rst_pend", 32'(reg2_pending), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 2 counter load
        wr(SEL_CV, 8'haa);
        check("cv_load", 32'(counter_load), 32'd1);
        check("cv_ack", 32'(ack), 32'd1);
        check("cv_ready", 32'(ready), 32'd0);
        check("cv_value", 32'(counter_load_value), 32'haa);
        check("cv_err", 32'(error), 32'd0);
        idle_cycle();
        check("cv_load_off", 32'(counter_load), 32'd0);
        check("cv_ready_back", 32'(ready), 32'd1);
        check("cv_value_hold", 32'(counter_load_value), 32'haa);

        // 3 register_2 commit
        we_count = 0;
        wr(SEL_MSB, 8'hbe);
        check("msb_pend", 32'(reg2_pending), 32'd1);
        check("msb_we", 32'(register_2_we), 32'd0);
        idle_cycle();
        wr(SEL_LSB, 8'hef);
        check("lsb_we", 32'(register_2_we), 32'd1);
        check("lsb_value", 32'(register_2_value), 32'hbeef);
        check("lsb_pend", 32'(reg2_pending), 32'd0);
        check("lsb_err", 32'(error), 32'd0);
        idle_cycle();
        check("lsb_we_off", 32'(register_2_we), 32'd0);
        check("commit_count", 32'(we_count), 32'd1);

        // 4 sequence errors
        wr(SEL_LSB, 8'h12);
        check("orphan_err", 32'(error), 32'd1);
        check("orphan_ack", 32'(ack), 32'd1);
        check("orphan_we", 32'(register_2_we), 32'd0);
        check("orphan_value", 32'(register_2_value), 32'hbeef);
        idle_cycle();
        check("orphan_err_off", 32'(error), 32'd0);
        wr(SEL_BAD, 8'h5a);
        check("badsel_err", 32'(error), 32'd1);
        check("badsel_ack", 32'(ack), 32'd1);
        check("badsel_cload", 32'(counter_load), 32'd0);
        check("badsel_clv", 32'(counter_load_value), 32'haa);
        check("badsel_pend", 32'(reg2_pending), 32'd0);
        check("badsel_value", 32'(register_2_value), 32'hbeef);
        idle_cycle();

        // 5 interleave and overwrite
        we_count = 0;
        wr(SEL_MSB, 8'h11);
        idle_cycle();
        wr(SEL_CV, 8'h55);
        check("il_pend_kept", 32'(reg2_pending), 32'd1);
        check("il_cload", 32'(counter_load), 32'd1);
        idle_cycle();
        wr(SEL_MSB, 8'h22);
        check("il_msb2_err", 32'(error), 32'd0);
        idle_cycle();
        wr(SEL_LSB, 8'h33);
        check("il_we", 32'(register_2_we), 32'd1);
        idle_cycle();
        check("il_clv", 32'(counter_load_value), 32'h55);
        check("il_value", 32'(register_2_value), 32'h2233);
        check("il_count", 32'(we_count), 32'd1);
        check("il_pend", 32'(reg2_pending), 32'd0);

        // 6 carry clear and mid-operation reset
        wr(SEL_CC, 8'h01);
        check("cc1_clr", 32'(counter_carry_clr), 32'd1);
        check("cc1_err", 32'(error), 32'd0);
        idle_cycle();
        check("cc1_clr_off", 32'(counter_carry_clr), 32'd0);
        wr(SEL_CC, 8'h00);
        check("cc0_clr", 32'(counter_carry_clr), 32'd0);
        check("cc0_ack", 32'(ack), 32'd1);
        check("cc0_err", 32'(error), 32'd0);
        idle_cycle();
        wr(SEL_MSB, 8'h77);
        check("mr_pend", 32'(reg2_pending), 32'd1);
        idle_cycle();
        // Reset must win over a same-cycle write.
        @(negedge clk);
        reset   = 1'b1;
        wr_en   = 1'b1;
        sel     = SEL_CV;
        data_in = 8'hff;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("mr_ack", 32'(ack), 32'd0);
        check("mr_cload", 32'(counter_load), 32'd0);
        check("mr_clv", 32'(counter_load_value), 32'h00);
        check("mr_pend_clr", 32'(reg2_pending), 32'd0);
        check("mr_value", 32'(register_2_value), 32'h0000);
        check("mr_ready", 32'(ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        wr(SEL_LSB, 8'h88);
        check("mr_lsb_err", 32'(error), 32'd1);
        check("mr_lsb_we", 32'(register_2_we), 32'd0);
        check("mr_lsb_value", 32'(register_2_value), 32'h0000);
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
